// File: rtl/ysyx_25020047_pkg.sv
// ysyx_25020047_pkg: shared encodings for the write-back stage and load extraction
package ysyx_25020047_pkg;
  typedef enum logic [1:0] {WB_NONE = 2'd0, WB_ALU = 2'd1, WB_SNPC = 2'd2, WB_MEM = 2'd3} wb_sel_e;
  localparam logic NPC_SNPC = 1'b0;
  localparam logic NPC_RES = 1'b1;
  typedef enum logic [2:0] {
    LD_LB = 3'b000, LD_LH = 3'b001, LD_LW = 3'b010, LD_LD = 3'b011,
    LD_LBU = 3'b100, LD_LHU = 3'b101, LD_LWU = 3'b110
  } ld_fmt_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT_MEM = 2'd1, ST_COMMIT = 2'd2} state_e;
endpackage

// File: rtl/ysyx_25020047_wbu_stage_if.sv
// ysyx_25020047_wbu_stage_if: descriptor, memory-return and commit signals of the write-back stage
interface ysyx_25020047_wbu_stage_if #(parameter int XLEN = 32, parameter int CNT_W = 64);
  logic in_valid;
  logic in_ready;
  logic [1:0] in_wb_sel;
  logic in_npc_sel;
  logic [4:0] in_rd;
  logic [2:0] in_ld_fmt;
  logic [XLEN-1:0] in_result;
  logic [XLEN-1:0] in_snpc;
  logic mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic out_valid;
  logic out_ready;
  logic rf_wen;
  logic [4:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [XLEN-1:0] dnpc;
  logic [CNT_W-1:0] instret;
  modport master(
    output in_valid, in_wb_sel, in_npc_sel, in_rd, in_ld_fmt, in_result, in_snpc, mem_rvalid, mem_rdata, out_ready,
    input in_ready, out_valid, rf_wen, rf_waddr, rf_wdata, dnpc, instret
  );
  modport slave(
    input in_valid, in_wb_sel, in_npc_sel, in_rd, in_ld_fmt, in_result, in_snpc, mem_rvalid, mem_rdata, out_ready,
    output in_ready, out_valid, rf_wen, rf_waddr, rf_wdata, dnpc, instret
  );
endinterface

// File: rtl/ysyx_25020047_ld_extract.sv
// ysyx_25020047_ld_extract: shifts the addressed bytes down and sign/zero-extends them per load format
module ysyx_25020047_ld_extract
  import ysyx_25020047_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  fmt,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [XLEN-1:0]             rdata,
  output logic [XLEN-1:0]             data,
  output logic                        legal
);
  logic [XLEN-1:0] sh;
  always_comb begin
    sh = rdata >> {off, 3'b000};
    legal = (fmt != 3'b111) && !(XLEN == 32 && (fmt == LD_LD || fmt == LD_LWU));
    data = !legal ? '0 :
           fmt == LD_LB  ? XLEN'($signed(sh[7:0])) :
           fmt == LD_LH  ? XLEN'($signed(sh[15:0])) :
           fmt == LD_LW  ? XLEN'($signed(sh[31:0])) :
           fmt == LD_LBU ? XLEN'(sh[7:0]) :
           fmt == LD_LHU ? XLEN'(sh[15:0]) :
           fmt == LD_LWU ? XLEN'(sh[31:0]) : sh;
  end
endmodule

// File: rtl/ysyx_25020047_wbu_stage.sv
// ysyx_25020047_wbu_stage: registered write-back stage; waits for load data, then emits one commit beat
module ysyx_25020047_wbu_stage
  import ysyx_25020047_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNT_W = 64
) (
  input logic clk,
  input logic rst_n,
  ysyx_25020047_wbu_stage_if.slave bus
);
  localparam int OFF_W = $clog2(XLEN/8);
  state_e state_q, state_d;
  logic rf_wen_q, rf_wen_d;
  logic [4:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d, dnpc_q, dnpc_d, ld_data;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [2:0] fmt_q, fmt_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic ld_legal, acc, fire, is_mem;
  ysyx_25020047_ld_extract #(.XLEN(XLEN)) u_ld_extract (
    .fmt(fmt_q), .off(off_q), .rdata(bus.mem_rdata), .data(ld_data), .legal(ld_legal)
  );
  assign bus.out_valid = state_q == ST_COMMIT;
  assign bus.in_ready = state_q == ST_IDLE || (state_q == ST_COMMIT && bus.out_ready);
  assign bus.rf_wen = rf_wen_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.dnpc = dnpc_q;
  assign bus.instret = instret_q;
  always_comb begin
    state_d = state_q;
    rf_wen_d = rf_wen_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    dnpc_d = dnpc_q;
    fmt_d = fmt_q;
    off_d = off_q;
    acc = bus.in_valid && bus.in_ready;
    fire = bus.out_valid && bus.out_ready;
    is_mem = bus.in_wb_sel == WB_MEM;
    instret_d = instret_q + CNT_W'(fire);
    if (state_q == ST_WAIT_MEM && bus.mem_rvalid) begin
      state_d = ST_COMMIT;
      rf_wen_d = ld_legal && rf_waddr_q != 5'd0;
      rf_wdata_d = ld_data;
    end else if (acc) begin
      state_d = is_mem ? ST_WAIT_MEM : ST_COMMIT;
      rf_waddr_d = bus.in_rd;
      dnpc_d = bus.in_npc_sel == NPC_RES ? {bus.in_result[XLEN-1:1], 1'b0} : bus.in_snpc;
      rf_wen_d = !is_mem && bus.in_wb_sel != WB_NONE && bus.in_rd != 5'd0;
      rf_wdata_d = bus.in_wb_sel == WB_ALU ? bus.in_result : bus.in_wb_sel == WB_SNPC ? bus.in_snpc : '0;
      fmt_d = bus.in_ld_fmt;
      off_d = bus.in_result[OFF_W-1:0];
    end else if (fire) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rf_wen_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      dnpc_q <= '0;
      instret_q <= '0;
      fmt_q <= '0;
      off_q <= '0;
    end else begin
      state_q <= state_d;
      rf_wen_q <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      dnpc_q <= dnpc_d;
      instret_q <= instret_d;
      fmt_q <= fmt_d;
      off_q <= off_d;
    end
  end
endmodule
